// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes, FSM state encoding and access-size helper shared by dmem_responder
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} dmem_state_e;

    function automatic logic [3:0] size_of(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering between an 8-byte memory row and load/store data
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [2:0]  i_off,
    input  logic [63:0] i_row,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_ldata,
    output logic [7:0]  o_be,
    output logic [63:0] o_wbytes
);
    logic [63:0] w_shr;
    logic [7:0]  w_mask;

    assign w_shr    = i_row >> {i_off, 3'b000};
    assign o_ldata  = (i_funct3 == F3_B)  ? {{56{w_shr[7]}}, w_shr[7:0]} :
                      (i_funct3 == F3_H)  ? {{48{w_shr[15]}}, w_shr[15:0]} :
                      (i_funct3 == F3_W)  ? {{32{w_shr[31]}}, w_shr[31:0]} :
                      (i_funct3 == F3_D)  ? w_shr :
                      (i_funct3 == F3_BU) ? {56'd0, w_shr[7:0]} :
                      (i_funct3 == F3_HU) ? {48'd0, w_shr[15:0]} :
                      (i_funct3 == F3_WU) ? {32'd0, w_shr[31:0]} : 64'd0;
    assign w_mask   = (i_funct3[1:0] == 2'd0) ? 8'h01 :
                      (i_funct3[1:0] == 2'd1) ? 8'h03 :
                      (i_funct3[1:0] == 2'd2) ? 8'h0F : 8'hFF;
    assign o_be     = w_mask << i_off;
    assign o_wbytes = i_wdata << {i_off, 3'b000};
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle load/store target for the MEM stage; DMEM_MISALIGN_TRAP_EN makes misaligned accesses fault instead of being aligned down
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              stall
);
    localparam int AW = $clog2(DEPTH);

    dmem_state_e       r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;
    logic [2:0]        r_f3;
    logic              r_rsp_valid;
    logic [63:0]       r_rdata;
    logic              r_err;
    logic [7:0]        r_mem [DEPTH];

    logic [3:0]        w_size;
    logic [2:0]        w_amask;
    logic [2:0]        w_off;
    logic [AW-1:0]     w_base;
    logic [63:0]       w_row;
    logic [63:0]       w_ldata;
    logic [63:0]       w_wbytes;
    logic [7:0]        w_be;
    logic              w_range_err;
    logic              w_f3_err;
    logic              w_align_err;
    logic              w_err;
    logic              w_fire;

    assign w_size      = size_of(r_f3);
    assign w_amask     = w_size[2:0] - 3'd1;
    assign w_range_err = ({1'b0, r_addr} + (ADDR_W+1)'(w_size)) > (ADDR_W+1)'(DEPTH);
    assign w_f3_err    = r_we ? r_f3[2] : (r_f3 == 3'b111);
`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_align_err = (r_addr[2:0] & w_amask) != 3'd0;
    assign w_off       = r_addr[2:0];
`else
    assign w_align_err = 1'b0;
    assign w_off       = r_addr[2:0] & ~w_amask;
`endif
    assign w_err       = w_range_err | w_f3_err | w_align_err;
    assign w_base      = r_addr[AW-1:0] & ~AW'(7);
    assign w_fire      = (r_state == DMEM_WAIT) && (r_cnt == 4'd0);

    // gather the naturally aligned 8-byte row that contains the access
    always_comb begin
        w_row = '0;
        for (int i = 0; i < 8; i++) w_row[i*8 +: 8] = r_mem[w_base + AW'(i)];
    end

    dmem_lane_align u_align (
        .i_funct3 (r_f3),
        .i_off    (w_off),
        .i_row    (w_row),
        .i_wdata  (r_wdata),
        .o_ldata  (w_ldata),
        .o_be     (w_be),
        .o_wbytes (w_wbytes)
    );

    // store commit on the final wait edge; any fault drops the whole write and the array is never cleared
    always_ff @(posedge clk) begin
        if (w_fire && r_we && !w_err)
            for (int i = 0; i < 8; i++)
                if (w_be[i]) r_mem[w_base + AW'(i)] <= w_wbytes[i*8 +: 8];
    end

    // request capture, latency countdown and response hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= DMEM_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 64'd0;
            r_f3        <= 3'd0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 64'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                DMEM_IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_f3    <= req_funct3;
                    r_cnt   <= 4'(LATENCY - 1);
                    r_state <= DMEM_WAIT;
                end
                DMEM_WAIT: if (r_cnt == 4'd0) begin
                    r_rsp_valid <= 1'b1;
                    r_rdata     <= (r_we || w_err) ? 64'd0 : w_ldata;
                    r_err       <= w_err;
                    r_state     <= DMEM_RESP;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                DMEM_RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= DMEM_IDLE;
                end
                default: r_state <= DMEM_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == DMEM_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    // a presented request holds the pipeline whether idle or busy, so both cases reduce to req_valid
    assign stall     = req_valid;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table vectors, corner sequences and random traffic checked against a byte-array model
module tb_dmem_responder;
    localparam int MEM_BYTES = 256;

    typedef struct {
        string       nm;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  f3;
        logic [63:0] rd;
        logic        er;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic req_ready, rsp_valid, rsp_err, stall;
    logic [63:0] rsp_rdata;

    logic v3 = 1'b0, we3 = 1'b0, rr3 = 1'b1;
    logic [63:0] a3 = '0, wd3 = '0;
    logic [2:0]  f33 = '0;
    logic rq3, rv3, re3, st3;
    logic [63:0] rd3;

    logic [7:0] mem_m [MEM_BYTES];
    vec_t vt[$];
    int n_pass = 0;
    int n_tot = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(2), .ADDR_W(64)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(3), .ADDR_W(64)) dut3 (
        .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rq3), .req_we(we3),
        .req_addr(a3), .req_wdata(wd3), .req_funct3(f33), .rsp_valid(rv3),
        .rsp_ready(rr3), .rsp_rdata(rd3), .rsp_err(re3), .stall(st3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t mk(input string nm, input logic we, input logic [63:0] addr,
                                input logic [63:0] wd, input logic [2:0] f3, input logic [63:0] rd, input logic er);
        vec_t v;
        v.nm = nm; v.we = we; v.addr = addr; v.wdata = wd; v.f3 = f3; v.rd = rd; v.er = er;
        return v;
    endfunction

    // reference: an access is a plain byte-array read or write of 1<<f3[1:0] bytes
    function automatic void model(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                                  input logic [2:0] f3, output logic [63:0] rd, output logic er);
        int size;
        logic [63:0] a;
        logic [63:0] v;
        size = 1 << f3[1:0];
        a = addr;
        v = '0;
        rd = '0;
        er = we ? f3[2] : (f3 == 3'd7);
        if ({1'b0, addr} + 65'(size) > 65'(MEM_BYTES)) er = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (addr % 64'(size) != 64'd0) er = 1'b1;
`else
        a = addr - (addr % 64'(size));
`endif
        if (er) return;
        for (int i = 0; i < size; i++) begin
            if (we) mem_m[int'(a) + i] = wdata[8*i +: 8];
            else v[8*i +: 8] = mem_m[int'(a) + i];
        end
        if (!we && !f3[2] && size < 8 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
        if (!we) rd = v;
    endfunction

    task automatic xact(input logic we, input logic [63:0] addr, input logic [63:0] wdata, input logic [2:0] f3,
                        output logic [63:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd, erd;
        logic er, eer;
        int lat;
        #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_err", rsp_err, 0);
        chk("reset_stall", stall, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < MEM_BYTES / 8; r++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            xact(1'b1, 64'(r * 8), d, 3'd3, rd, er, lat);
            model(1'b1, 64'(r * 8), d, 3'd3, erd, eer);
            chk("init_err", er, 0);
        end

        // reset before the commit edge loses the store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h10; req_wdata = 64'h1122334455667788; req_funct3 = 3'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midwait_req_ready", req_ready, 1);
        chk("midwait_rsp_valid", rsp_valid, 0);
        chk("midwait_stall", stall, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midwait_no_rsp", rsp_valid, 0);
        xact(1'b0, 64'h10, 0, 3'd3, rd, er, lat);
        model(1'b0, 64'h10, 0, 3'd3, erd, eer);
        chk("midwait_ld_prior", rd, erd);
        chk("midwait_ld_err", er, 0);

        // reset after the commit edge keeps the store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h18; req_wdata = 64'hCAFEF00D12345678; req_funct3 = 3'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("postcommit_rsp_valid", rsp_valid, 1);
        reset = 1'b1;
        model(1'b1, 64'h18, 64'hCAFEF00D12345678, 3'd3, erd, eer);
        @(negedge clk);
        reset = 1'b0;
        xact(1'b0, 64'h18, 0, 3'd3, rd, er, lat);
        chk("postcommit_ld", rd, 64'hCAFEF00D12345678);

        vt.push_back(mk("sd20", 1, 64'h20, 64'h80FF7F01AABBCCDD, 3'd3, 64'd0, 0));
        vt.push_back(mk("lb20", 0, 64'h20, 0, 3'd0, 64'hFFFFFFFFFFFFFFDD, 0));
        vt.push_back(mk("lbu20", 0, 64'h20, 0, 3'd4, 64'hDD, 0));
        vt.push_back(mk("lh24", 0, 64'h24, 0, 3'd1, 64'h7F01, 0));
        vt.push_back(mk("lw24", 0, 64'h24, 0, 3'd2, 64'hFFFFFFFF80FF7F01, 0));
        vt.push_back(mk("lwu24", 0, 64'h24, 0, 3'd6, 64'h80FF7F01, 0));
        vt.push_back(mk("ld20", 0, 64'h20, 0, 3'd3, 64'h80FF7F01AABBCCDD, 0));
        vt.push_back(mk("sdF8", 1, 64'hF8, 64'h0123456789ABCDEF, 3'd3, 64'd0, 0));
        vt.push_back(mk("swFE", 1, 64'hFE, 64'hDEADBEEF, 3'd2, 64'd0, 1));
        vt.push_back(mk("ldF8", 0, 64'hF8, 0, 3'd3, 64'h0123456789ABCDEF, 0));
        vt.push_back(mk("st_f3_100", 1, 64'h20, 64'h55, 3'd4, 64'd0, 1));
        vt.push_back(mk("ld20_again", 0, 64'h20, 0, 3'd3, 64'h80FF7F01AABBCCDD, 0));
        vt.push_back(mk("ld_f3_111", 0, 64'h20, 0, 3'd7, 64'd0, 1));
`ifdef DMEM_MISALIGN_TRAP_EN
        vt.push_back(mk("lw21", 0, 64'h21, 0, 3'd2, 64'd0, 1));
`else
        vt.push_back(mk("lw21", 0, 64'h21, 0, 3'd2, 64'hFFFFFFFFAABBCCDD, 0));
`endif
        vt.push_back(mk("lh26", 0, 64'h26, 0, 3'd1, 64'hFFFFFFFFFFFF80FF, 0));
        vt.push_back(mk("sh22", 1, 64'h22, 64'h1234, 3'd1, 64'd0, 0));
        vt.push_back(mk("ld20_sh", 0, 64'h20, 0, 3'd3, 64'h80FF7F011234CCDD, 0));
        vt.push_back(mk("lbuFF", 0, 64'hFF, 0, 3'd4, 64'h01, 0));
        vt.push_back(mk("lhFF", 0, 64'hFF, 0, 3'd1, 64'd0, 1));
        vt.push_back(mk("ld_huge", 0, 64'hFFFFFFFFFFFFFFF8, 0, 3'd3, 64'd0, 1));
        vt.push_back(mk("sd100", 1, 64'h100, 64'h77, 3'd3, 64'd0, 1));

        foreach (vt[k]) begin
            xact(vt[k].we, vt[k].addr, vt[k].wdata, vt[k].f3, rd, er, lat);
            model(vt[k].we, vt[k].addr, vt[k].wdata, vt[k].f3, erd, eer);
            chk({vt[k].nm, "_rdata"}, rd, vt[k].rd);
            chk({vt[k].nm, "_err"}, er, vt[k].er);
            chk({vt[k].nm, "_lat"}, lat, 2);
        end

        for (int t = 0; t < 60; t++) begin
            logic w;
            logic [63:0] a, d;
            logic [2:0] f;
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 9) == 0) ? {32'hFFFF_FFFF, $urandom} : 64'($urandom_range(0, 263));
            d = {$urandom, $urandom};
            xact(w, a, d, f, rd, er, lat);
            model(w, a, d, f, erd, eer);
            chk($sformatf("rand%0d_rdata", t), rd, erd);
            chk($sformatf("rand%0d_err", t), er, eer);
        end

        // LATENCY=3 instance: response timing and hold under backpressure
        @(negedge clk);
        v3 = 1'b1; we3 = 1'b1; a3 = 64'h40; wd3 = 64'h0F1E2D3C4B5A6978; f33 = 3'd3; rr3 = 1'b1;
        @(posedge clk); #1;
        v3 = 1'b0;
        lat = 0;
        while (!rv3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("l3_store_lat", lat, 3);
        @(posedge clk); #1;
        @(negedge clk);
        v3 = 1'b1; we3 = 1'b0; rr3 = 1'b0;
        #1;
        chk("l3_stall_req", st3, 1);
        @(posedge clk); #1;
        v3 = 1'b0;
        chk("l3_stall_drop", st3, 0);
        lat = 0;
        while (!rv3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("l3_load_lat", lat, 3);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("l3_hold_valid", rv3, 1);
            chk("l3_hold_rdata", rd3, 64'h0F1E2D3C4B5A6978);
            chk("l3_hold_req_ready", rq3, 0);
        end
        @(negedge clk);
        rr3 = 1'b1;
        @(posedge clk); #1;
        chk("l3_rsp_clear", rv3, 0);
        chk("l3_idle_ready", rq3, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
